// File: rtl/ml_net_pkg.sv
// Shared definitions for the conv-layer weight loading path.
package ml_net_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_LOADED
    } loader_state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // Each channel stores its KxK weights followed by KxK biases.
    function automatic int unsigned words_per_kernel(input int unsigned kernel_size);
        return 2 * kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and programmable step.
module counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] count_by_i,
    output logic [Width-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + count_by_i;
        end
    end

endmodule

// File: rtl/rd_valid_pipe.sv
// Delays each read enable by the RAM read latency to mark the cycle its data arrives.
module rd_valid_pipe #(
    parameter int unsigned ReadLatency = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ren_i,
    output logic capture_o
);

    logic [ReadLatency:1] vld_pipe;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= ReadLatency'({vld_pipe, ren_i});
        end
    end

    assign capture_o = vld_pipe[ReadLatency];

endmodule

// File: rtl/weight_bank_loader.sv
// Double-buffered weight/bias loader: streams BRAM words into a shadow bank,
// then commits the whole bank to the active outputs on update_i.
module weight_bank_loader
    import ml_net_pkg::*;
#(
    parameter int unsigned N           = 10,
    parameter int unsigned KernelSize  = 8,
    parameter int unsigned Channels    = 4,
    parameter int unsigned AddrSize    = 12,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         start_i,
    input  logic [AddrSize-1:0]                          base_addr_i,
    input  logic                                         update_i,
    output logic                                         ready_o,
    output logic                                         loaded_o,
    output logic                                         valid_o,
    output logic [Channels*2*N*KernelSize*KernelSize-1:0] weights_o,
    output logic                                         ram_rd_en_o,
    output logic [AddrSize-1:0]                          ram_addr_o,
    input  logic [N-1:0]                                 ram_data_i
);

    localparam int unsigned WordsPerCh = words_per_kernel(KernelSize);
    localparam int unsigned Total      = Channels * WordsPerCh;
    localparam int unsigned CntW       = $clog2(Total + 1);

    if (ReadLatency < RD_LAT_MIN || ReadLatency > RD_LAT_MAX) begin : g_bad_latency
        $error("weight_bank_loader: ReadLatency out of range");
    end

    loader_state_e state_q, state_d;
    logic [AddrSize-1:0]      base_q;
    logic [CntW-1:0]          issue_idx, capture_idx;
    logic [Total-1:0][N-1:0]  shadow_q;
    logic                     capture, accept, commit;

    assign ready_o     = (state_q == ST_IDLE) || (state_q == ST_LOADED);
    assign loaded_o    = (state_q == ST_LOADED);
    assign ram_rd_en_o = (state_q == ST_FETCH);
    assign ram_addr_o  = ram_rd_en_o ? base_q + AddrSize'(issue_idx) : '0;
    assign accept      = ready_o && start_i;
    assign commit      = loaded_o && update_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_FETCH;
            ST_FETCH:  if (issue_idx == CntW'(Total - 1)) state_d = ST_DRAIN;
            ST_DRAIN:  if (capture && capture_idx == CntW'(Total - 1)) state_d = ST_LOADED;
            ST_LOADED: begin
                // A start here wins over going idle; any commit happens on the same edge.
                if (start_i)       state_d = ST_FETCH;
                else if (update_i) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            valid_o   <= 1'b0;
            weights_o <= '0;
        end else begin
            state_q <= state_d;
            if (accept) base_q <= base_addr_i;
            if (commit) begin
                weights_o <= shadow_q;
                valid_o   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(Total); k++) begin
            if (capture && capture_idx == CntW'(k)) shadow_q[k] <= ram_data_i;
        end
    end

    counter #(.Width(CntW)) u_issue_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (accept),
        .en_i       (ram_rd_en_o),
        .count_by_i (CntW'(1)),
        .count_o    (issue_idx)
    );

    counter #(.Width(CntW)) u_capture_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (accept),
        .en_i       (capture),
        .count_by_i (CntW'(1)),
        .count_o    (capture_idx)
    );

    rd_valid_pipe #(.ReadLatency(ReadLatency)) u_rd_valid_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ren_i     (ram_rd_en_o),
        .capture_o (capture)
    );

endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed bench for weight_bank_loader: one instance at read latency 1, one at latency 3.
module tb_weight_bank_loader;

    logic        clk;
    logic        rst_n;
    logic        start, update;
    logic [5:0]  base;
    logic        ready, loaded, valid, rd_en;
    logic [63:0] weights;
    logic [5:0]  ram_addr;
    logic [3:0]  ram_data;

    logic        start3, update3;
    logic [5:0]  base3;
    logic        ready3, loaded3, valid3, rd_en3;
    logic [63:0] weights3;
    logic [5:0]  ram_addr3;
    logic [3:0]  ram_data3, p1, p2;

    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] wts_exp;
    logic        vld_exp;

    weight_bank_loader #(.N(4), .KernelSize(2), .Channels(2), .AddrSize(6), .ReadLatency(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .update_i(update),
        .ready_o(ready), .loaded_o(loaded), .valid_o(valid), .weights_o(weights),
        .ram_rd_en_o(rd_en), .ram_addr_o(ram_addr), .ram_data_i(ram_data)
    );

    weight_bank_loader #(.N(4), .KernelSize(2), .Channels(2), .AddrSize(6), .ReadLatency(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .base_addr_i(base3), .update_i(update3),
        .ready_o(ready3), .loaded_o(loaded3), .valid_o(valid3), .weights_o(weights3),
        .ram_rd_en_o(rd_en3), .ram_addr_o(ram_addr3), .ram_data_i(ram_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word at address a is a[3:0]
    always @(posedge clk) begin
        ram_data  <= ram_addr[3:0];
        p1        <= ram_addr3[3:0];
        p2        <= p1;
        ram_data3 <= p2;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_w(input logic [5:0] b);
        logic [63:0] w;
        logic [5:0]  a;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            a = b + 6'(k);
            w[k*4 +: 4] = a[3:0];
        end
        return w;
    endfunction

    task automatic do_load(input logic [5:0] b, input bit upd, input bit mid);
        logic [5:0] a;
        base = b; start = 1'b1; update = upd;
        step();
        start = 1'b0; update = 1'b0; base = 6'h3F;
        for (int i = 0; i < 16; i++) begin
            a = b + 6'(i);
            chk("fetch_rd_en", 64'(rd_en), 64'd1);
            chk("fetch_addr", 64'(ram_addr), 64'(a));
            chk("fetch_ready", 64'(ready), 64'd0);
            chk("fetch_loaded", 64'(loaded), 64'd0);
            chk("fetch_wts", weights, wts_exp);
            chk("fetch_valid", 64'(valid), 64'(vld_exp));
            if (mid && i == 5) begin
                update = 1'b1; start = 1'b1;
            end
            step();
            update = 1'b0; start = 1'b0;
        end
        chk("drain_rd_en", 64'(rd_en), 64'd0);
        chk("drain_ready", 64'(ready), 64'd0);
        chk("drain_loaded", 64'(loaded), 64'd0);
        step();
        chk("loaded", 64'(loaded), 64'd1);
        chk("loaded_ready", 64'(ready), 64'd1);
        chk("loaded_rd_en", 64'(rd_en), 64'd0);
        chk("loaded_wts", weights, wts_exp);
    endtask

    task automatic commit(input logic [5:0] b);
        update = 1'b1;
        step();
        update = 1'b0;
        wts_exp = exp_w(b);
        vld_exp = 1'b1;
        chk("commit_wts", weights, wts_exp);
        chk("commit_valid", 64'(valid), 64'd1);
        chk("commit_loaded", 64'(loaded), 64'd0);
        chk("commit_ready", 64'(ready), 64'd1);
        chk("commit_rd_en", 64'(rd_en), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; update = 1'b0; base = '0;
        start3 = 1'b0; update3 = 1'b0; base3 = '0;
        wts_exp = '0; vld_exp = 1'b0;
        step(); step();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_wts", weights, 64'd0);
        rst_n = 1'b1;
        step();

        // basic load
        do_load(6'h08, 1'b0, 1'b0);
        commit(6'h08);
        chk("basic_wts_const", weights, 64'h76543210FEDCBA98);

        // address wrap
        do_load(6'h38, 1'b0, 1'b0);
        commit(6'h38);
        chk("wrap_word8", 64'(weights[35:32]), 64'd0);

        // stray update/start mid-fetch; active bank stays on the previous commit
        do_load(6'h05, 1'b0, 1'b1);
        // start+update together: commit B at this edge, next load begins immediately
        wts_exp = exp_w(6'h05);
        vld_exp = 1'b1;
        do_load(6'h2A, 1'b1, 1'b0);
        chk("overlap_b_const", exp_w(6'h05) ^ weights, 64'd0);
        commit(6'h2A);
        chk("overlap_c_const", weights, 64'h9876543210FEDCBA);

        // start in LOADED without update discards the shadow
        do_load(6'h00, 1'b0, 1'b0);
        do_load(6'h03, 1'b0, 1'b0);
        commit(6'h03);

        // reset during DRAIN
        base = 6'h11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        chk("pre_rst_drain_rd_en", 64'(rd_en), 64'd0);
        chk("pre_rst_drain_loaded", 64'(loaded), 64'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_loaded", 64'(loaded), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        chk("midrst_addr", 64'(ram_addr), 64'd0);
        chk("midrst_wts", weights, 64'd0);
        wts_exp = '0; vld_exp = 1'b0;
        step();
        chk("post_rst_loaded", 64'(loaded), 64'd0);
        do_load(6'h21, 1'b0, 1'b0);
        commit(6'h21);
        chk("post_rst_wts_const", weights, 64'h0FEDCBA987654321);

        // read latency 3 instance
        base3 = 6'h0B; start3 = 1'b1;
        step();
        start3 = 1'b0; base3 = 6'h00;
        for (int i = 0; i < 16; i++) begin
            chk("rl3_rd_en", 64'(rd_en3), 64'd1);
            chk("rl3_addr", 64'(ram_addr3), 64'(6'(6'h0B + 6'(i))));
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("rl3_not_loaded", 64'(loaded3), 64'd0);
            chk("rl3_drain_rd_en", 64'(rd_en3), 64'd0);
            step();
        end
        chk("rl3_loaded", 64'(loaded3), 64'd1);
        update3 = 1'b1;
        step();
        update3 = 1'b0;
        chk("rl3_wts", weights3, exp_w(6'h0B));
        chk("rl3_valid", 64'(valid3), 64'd1);
        chk("rl3_loaded_drop", 64'(loaded3), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
